axil_sdm_reg_bank: RTL and testbench
====================================

// Module: axil_sdm_reg_bank
// PURPOSE
//  AXI4-Lite slave register bank controlling CHANNELS sigma-delta modulator channels.
//  Per-channel enable bits and double-buffered (shadow/active) input values.
//  A COMMIT write transfers all shadows to the modulators in the same cycle.
//  Byte strobes, read-only ID register, SLVERR on bad accesses. Sits between the AXI interconnect and the modulator array.
// PARAMETERS
//  CHANNELS     4   number of modulator channels, 1..32
//  VALUE_WIDTH  16  bits per channel value, 8..32
//  ADDR_WIDTH   8   decoded address bits (awaddr/araddr[ADDR_WIDTH-1:0]); >=8
// PORTS
//  aclk          in   1                     clock, all logic rising-edge
//  aresetn       in   1                     synchronous reset, active-low
//  awaddr/awprot/awvalid/awready  in/in/in/out  32/3/1/1  AXI4-Lite write address
//  wdata/wstrb/wvalid/wready      in/in/in/out  32/4/1/1  AXI4-Lite write data
//  bresp/bvalid/bready            out/out/in    2/1/1     AXI4-Lite write response
//  araddr/arprot/arvalid/arready  in/in/in/out  32/3/1/1  AXI4-Lite read address
//  rdata/rresp/rvalid/rready      out/out/out/in 32/2/1/1 AXI4-Lite read data
//  enable        out  CHANNELS              per-channel enable, bit n -> channel n
//  value         out  CHANNELS*VALUE_WIDTH  active values, channel n at [n*VALUE_WIDTH +: VALUE_WIDTH]
//  value_update  out  1                     1-cycle pulse: active values just changed
// BEHAVIOUR
//  Reset: aresetn=0 at an edge -> all FSMs idle; enable, value, shadows, value_update, bvalid, rvalid, rdata = 0.
//   Also on reset: bresp, rresp = 0; awready, wready, arready = 0.
//   Ready signals are registered and rise the first cycle after release.
//   Reset mid-transaction discards captured addr/data and any pending response.
//  Map (byte addr, 32-bit aligned; awprot/arprot ignored):
//   0x00 ENABLE  RW, bits[CHANNELS-1:0], other bits read 0
//   0x04 ID      RO = {8'h5D, 8'(VALUE_WIDTH), 8'(CHANNELS), 8'h02}
//   0x08 COMMIT  WO, bit0=1 -> commit; reads 0
//   0x10+4n VALUE[n] RW shadow, bits[VALUE_WIDTH-1:0], upper bits read 0, n<CHANNELS
//  SLVERR (2'b10), no state change: addr[1:0]!=0, unmapped addr, write to ID.
//  Otherwise OKAY (2'b00).
//  Write FSM W_IDLE -> W_EXEC -> W_RESP:
//   W_IDLE: awready=!aw_held, wready=!w_held. AW and W are captured independently, in any order or the same cycle.
//    Leave W_IDLE once both are held.
//   W_EXEC (1 cycle): decode; on the exiting edge apply wstrb byte-masked write and set bresp.
//    wstrb=0 -> OKAY, no change.
//   W_RESP: bvalid=1, bresp stable until bready; then W_IDLE, ready again next cycle.
//   Latency: AW+W same edge k -> register updated at k+2, bvalid high from cycle k+2.
//  COMMIT: if wstrb[0]&wdata[0] at the W_EXEC edge, every active value <= shadow.
//   value_update=1 for exactly the following cycle.
//   Commit with unchanged shadows still pulses. ENABLE writes take effect immediately, no pulse.
//  Read FSM R_IDLE -> R_DATA:
//   R_IDLE: arready=1. On AR handshake, rdata/rresp register from contents at that edge.
//    A write executing at the same edge is not visible.
//   R_DATA: rvalid=1, rdata/rresp stable until rready; then R_IDLE.
//   SLVERR reads return rdata=0.
//  Read and write paths are fully independent and may be concurrent.
// TESTING
//  1 Reset, read 0x04 (CH=4,VW=16) -> rdata=32'h5D100402 OKAY; ENABLE/VALUE read 0; value=0.
//  2 Write 0x14=0x00001234, read 0x14 -> 0x1234; value[31:16] stays 0.
//    Write 0x08=1 -> value[31:16]=0x1234, value_update high exactly 1 cycle.
//  3 W two cycles before AW, then AW alone; also AW+W same cycle -> each gets one bvalid OKAY.
//    Same-cycle case: update at k+2.
//  4 Write 0x10=0xAABBCCDD wstrb=4'b0010 over 0x0000 -> shadow 0xCC00.
//    Write 0x00=0xFFFFFFFF -> enable=4'hF, read 0x00=0x0000000F.
//  5 Write 0x04, 0x20 (n=4) and 0x12 -> SLVERR, no state change.
//    Read 0x0C -> SLVERR rdata 0. Hold bready/rready low 5 cycles -> responses held stable.
//  6 aresetn low during W_RESP and R_DATA -> bvalid/rvalid drop, regs 0.
//    Next clean write completes OKAY.

Source files
------------

// File: rtl/axil_sdm_reg_bank.sv
// AXI4-Lite register bank for an array of sigma-delta modulator channels.
// Holds per-channel enables and double-buffered channel values: software
// writes shadow copies, then a COMMIT write moves every shadow into the
// active set driving the modulators in a single cycle.
module axil_sdm_reg_bank #(
  parameter int CHANNELS    = 4,
  parameter int VALUE_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  // write address
  input  logic [31:0]                     awaddr,
  input  logic [2:0]                      awprot,
  input  logic                            awvalid,
  output logic                            awready,
  // write data
  input  logic [31:0]                     wdata,
  input  logic [3:0]                      wstrb,
  input  logic                            wvalid,
  output logic                            wready,
  // write response
  output logic [1:0]                      bresp,
  output logic                            bvalid,
  input  logic                            bready,
  // read address
  input  logic [31:0]                     araddr,
  input  logic [2:0]                      arprot,
  input  logic                            arvalid,
  output logic                            arready,
  // read data
  output logic [31:0]                     rdata,
  output logic [1:0]                      rresp,
  output logic                            rvalid,
  input  logic                            rready,
  // modulator array side
  output logic [CHANNELS-1:0]             enable,
  output logic [CHANNELS*VALUE_WIDTH-1:0] value,
  output logic                            value_update
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ID_WORD     = {8'h5D, 8'(VALUE_WIDTH), 8'(CHANNELS), 8'h02};
  localparam int          OFF_WIDTH   = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {K_ENABLE, K_ID, K_COMMIT, K_VALUE, K_BAD} kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [5:0] idx;   // channel index, meaningful only for K_VALUE
  } dec_t;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  // Classify a byte address into a register kind (and channel for VALUE).
  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] a);
    dec_t                  d;
    logic [ADDR_WIDTH-1:0] off;
    d.kind = K_BAD;
    d.idx  = '0;
    off    = a - ADDR_WIDTH'(16);
    if (a[1:0] != 2'b00) begin
      d.kind = K_BAD;
    end else if (a == ADDR_WIDTH'(0)) begin
      d.kind = K_ENABLE;
    end else if (a == ADDR_WIDTH'(4)) begin
      d.kind = K_ID;
    end else if (a == ADDR_WIDTH'(8)) begin
      d.kind = K_COMMIT;
    end else if ((a >= ADDR_WIDTH'(16)) && (off[ADDR_WIDTH-1:2] < OFF_WIDTH'(CHANNELS))) begin
      d.kind = K_VALUE;
      d.idx  = off[7:2];
    end
    return d;
  endfunction

  // Replace the bytes of old_word selected by strb with the matching bytes of data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  // Write path state
  wstate_e                 wstate_q, wstate_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [CHANNELS-1:0]     enable_q, enable_d;
  logic [VALUE_WIDTH-1:0]  shadow_q [CHANNELS];
  logic [VALUE_WIDTH-1:0]  shadow_d [CHANNELS];
  logic [VALUE_WIDTH-1:0]  active_q [CHANNELS];
  logic [VALUE_WIDTH-1:0]  active_d [CHANNELS];
  logic                    value_update_q, value_update_d;
  dec_t                    wdec;
  logic [31:0]             wr_old;
  logic [31:0]             wr_new;

  // Read path state
  rstate_e                 rstate_q, rstate_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  dec_t                    rdec;
  logic [31:0]             rd_word;

  // Protection bits and address bits above the decoded range do not matter.
  logic unused_bits;
  assign unused_bits = ^{awprot, arprot, awaddr[31:ADDR_WIDTH], araddr[31:ADDR_WIDTH]};

  // Write FSM next state: capture AW/W independently, execute, then respond.
  // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wstate_d       = wstate_q;
    aw_held_d      = aw_held_q;
    w_held_d       = w_held_q;
    awaddr_d       = awaddr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    bvalid_d       = bvalid_q;
    bresp_d        = bresp_q;
    enable_d       = enable_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    value_update_d = 1'b0;
    wdec           = decode(awaddr_q);
    wr_old         = '0;
    wr_new         = '0;

    case (wstate_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr[ADDR_WIDTH-1:0];
        end
        if (wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if (aw_held_d && w_held_d) wstate_d = W_EXEC;
      end

      W_EXEC: begin
        case (wdec.kind)
          K_ENABLE: wr_old[CHANNELS-1:0] = enable_q;
          K_VALUE: begin
            for (int n = 0; n < CHANNELS; n++) begin
              if (wdec.idx == 6'(n)) wr_old[VALUE_WIDTH-1:0] = shadow_q[n];
            end
          end
          default: wr_old = '0;
        endcase
        wr_new = merge_bytes(wr_old, wdata_q, wstrb_q);

        if ((wdec.kind == K_BAD) || (wdec.kind == K_ID)) begin
          bresp_d = RESP_SLVERR;
        end else begin
          bresp_d = RESP_OKAY;
          case (wdec.kind)
            K_ENABLE: enable_d = wr_new[CHANNELS-1:0];
            K_VALUE: begin
              for (int n = 0; n < CHANNELS; n++) begin
                if (wdec.idx == 6'(n)) shadow_d[n] = wr_new[VALUE_WIDTH-1:0];
              end
            end
            K_COMMIT: begin
              // Commit always pulses, even when shadows equal the active set.
              if (wstrb_q[0] && wdata_q[0]) begin
                active_d       = shadow_q;
                value_update_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
        bvalid_d = 1'b1;
        wstate_d = W_RESP;
      end

      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          wstate_d  = W_IDLE;
        end
      end

      default: wstate_d = W_IDLE;
    endcase

    // Readies are registered, so derive them from where the FSM is going.
    awready_d = (wstate_d == W_IDLE) && !aw_held_d;
    wready_d  = (wstate_d == W_IDLE) && !w_held_d;
  end

  // Write path registers, including the channel register file.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, with no ordering races.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wstate_q       <= W_IDLE;
      aw_held_q      <= 1'b0;
      w_held_q       <= 1'b0;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      awready_q      <= 1'b0;
      wready_q       <= 1'b0;
      bvalid_q       <= 1'b0;
      bresp_q        <= RESP_OKAY;
      enable_q       <= '0;
      value_update_q <= 1'b0;
      // NOTE: the shadow/active arrays are reset explicitly because the modulators must see zero values straight out of reset.
      for (int n = 0; n < CHANNELS; n++) begin
        shadow_q[n] <= '0;
        active_q[n] <= '0;
      end
    end else begin
      wstate_q       <= wstate_d;
      aw_held_q      <= aw_held_d;
      w_held_q       <= w_held_d;
      awaddr_q       <= awaddr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      awready_q      <= awready_d;
      wready_q       <= wready_d;
      bvalid_q       <= bvalid_d;
      bresp_q        <= bresp_d;
      enable_q       <= enable_d;
      value_update_q <= value_update_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
    end
  end

  // Read FSM next state: sample register contents on the AR handshake.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rdec     = decode(araddr[ADDR_WIDTH-1:0]);
    rd_word  = '0;

    case (rdec.kind)
      K_ENABLE: rd_word[CHANNELS-1:0] = enable_q;
      K_ID:     rd_word = ID_WORD;
      K_VALUE: begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (rdec.idx == 6'(n)) rd_word[VALUE_WIDTH-1:0] = shadow_q[n];
        end
      end
      default:  rd_word = '0;
    endcase

    case (rstate_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          rstate_d = R_DATA;
          rvalid_d = 1'b1;
          rdata_d  = rd_word;
          rresp_d  = (rdec.kind == K_BAD) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    arready_d = (rstate_d == R_IDLE);
  end

  // Read path registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Flatten the active values onto the modulator bus.
  always_comb begin
    value = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      value[n*VALUE_WIDTH +: VALUE_WIDTH] = active_q[n];
    end
  end

  assign awready      = awready_q;
  assign wready       = wready_q;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign arready      = arready_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;
  assign enable       = enable_q;
  assign value_update = value_update_q;

endmodule

// File: tb/tb_axil_sdm_reg_bank.sv
// Directed bench for axil_sdm_reg_bank with default parameters
// (CHANNELS=4, VALUE_WIDTH=16, ADDR_WIDTH=8).
module tb_axil_sdm_reg_bank;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [3:0]  enable;
  logic [63:0] value;
  logic        value_update;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int upd_cnt   = 0;
  int bhs_cnt   = 0;

  axil_sdm_reg_bank dut (
    .aclk(clk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .enable(enable), .value(value), .value_update(value_update)
  );

  always #5 clk = ~clk;

  // Count cycles with value_update high and completed write responses.
  always @(posedge clk) begin
    if (value_update) upd_cnt <= upd_cnt + 1;
    if (bvalid && bready) bhs_cnt <= bhs_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_pend, w_pend, aw_go, w_go;
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_pend = 1'b1; w_pend = 1'b1; n = 0;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_go = aw_pend && awready;
      w_go  = w_pend && wready;
      tick();
      if (aw_go) begin aw_pend = 1'b0; awvalid = 1'b0; end
      if (w_go)  begin w_pend  = 1'b0; wvalid  = 1'b0; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_accept", {62'd0, aw_pend, w_pend}, 64'd0);
    bready = 1'b1; n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("wr_bvalid", bvalid, 1);
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    rready = 1'b1; n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    check("rd_rvalid", rvalid, 1);
    d = rdata; resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  typedef struct {
    logic        is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic        stable;
    int          b0, n;

    vecs[0]  = '{1'b1, 32'h04, 32'h0,        4'h0, 32'h5D10_0402, 2'b00};
    vecs[1]  = '{1'b1, 32'h00, 32'h0,        4'h0, 32'h0,         2'b00};
    vecs[2]  = '{1'b1, 32'h14, 32'h0,        4'h0, 32'h0,         2'b00};
    vecs[3]  = '{1'b0, 32'h14, 32'h0000_1234, 4'hF, 32'h0,        2'b00};
    vecs[4]  = '{1'b1, 32'h14, 32'h0,        4'h0, 32'h0000_1234, 2'b00};
    vecs[5]  = '{1'b0, 32'h10, 32'hAABB_CCDD, 4'h2, 32'h0,        2'b00};
    vecs[6]  = '{1'b1, 32'h10, 32'h0,        4'h0, 32'h0000_CC00, 2'b00};
    vecs[7]  = '{1'b0, 32'h00, 32'hFFFF_FFFF, 4'hF, 32'h0,        2'b00};
    vecs[8]  = '{1'b1, 32'h00, 32'h0,        4'h0, 32'h0000_000F, 2'b00};
    vecs[9]  = '{1'b0, 32'h04, 32'hFFFF_FFFF, 4'hF, 32'h0,        2'b10};
    vecs[10] = '{1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0,        2'b10};
    vecs[11] = '{1'b0, 32'h12, 32'hFFFF_FFFF, 4'hF, 32'h0,        2'b10};
    vecs[12] = '{1'b1, 32'h0C, 32'h0,        4'h0, 32'h0,         2'b10};
    vecs[13] = '{1'b1, 32'h04, 32'h0,        4'h0, 32'h5D10_0402, 2'b00};
    vecs[14] = '{1'b1, 32'h08, 32'h0,        4'h0, 32'h0,         2'b00};
    vecs[15] = '{1'b0, 32'h1C, 32'hFFFF_FFFF, 4'h0, 32'h0,        2'b00};
    vecs[16] = '{1'b1, 32'h1C, 32'h0,        4'h0, 32'h0,         2'b00};
    vecs[17] = '{1'b1, 32'h12, 32'h0,        4'h0, 32'h0,         2'b10};
    vecs[18] = '{1'b1, 32'h14, 32'h0,        4'h0, 32'h0000_1234, 2'b00};

    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_enable", enable, 0);
    check("rst_value", value, 0);
    check("rst_rdata", rdata, 0);
    aresetn = 1'b1;
    tick();
    check("rel_ready", {61'd0, awready, wready, arready}, 64'h7);

    // Table-driven register accesses
    upd_cnt = 0;
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].is_rd) begin
        axi_read(vecs[i].addr, rd, resp);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
      end else begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
      end
    end
    check("enable_after_table", enable, 4'hF);
    check("value_before_commit", value, 0);
    check("no_pulse_without_commit", upd_cnt, 0);

    // Commit: shadows ch0=0xCC00, ch1=0x1234 move to active, one-cycle pulse
    upd_cnt = 0;
    axi_write(32'h08, 32'h1, 4'h1, resp);
    repeat (3) tick();
    check("commit_bresp", resp, 2'b00);
    check("commit_value", value, 64'h0000_0000_1234_CC00);
    check("commit_pulse_cycles", upd_cnt, 1);
    check("commit_pulse_low", value_update, 0);
    // Commit with unchanged shadows still pulses; bit0 clear does not
    upd_cnt = 0;
    axi_write(32'h08, 32'h1, 4'hF, resp);
    axi_write(32'h08, 32'hFFFF_FFFE, 4'hF, resp);
    repeat (3) tick();
    check("recommit_pulse_cycles", upd_cnt, 1);
    check("recommit_value", value, 64'h0000_0000_1234_CC00);

    // W two cycles before AW
    b0 = bhs_cnt;
    check("w_first_ready", wready, 1);
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    awaddr = 32'h00; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    bready = 1'b1; n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("w_first_bresp", {bvalid, bresp}, 3'b100);
    tick();
    bready = 1'b0;
    check("w_first_enable", enable, 4'h5);
    check("w_first_one_resp", bhs_cnt - b0, 1);

    // AW+W same cycle: register and bvalid change two cycles after the handshake
    b0 = bhs_cnt;
    check("same_ready", {awready, wready}, 2'b11);
    awaddr = 32'h00; wdata = 32'hA; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("same_k1", {enable, bvalid}, {4'h5, 1'b0});
    tick();
    check("same_k2", {enable, bvalid, bresp}, {4'hA, 1'b1, 2'b00});
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("same_bvalid_drop", bvalid, 0);
    check("same_one_resp", bhs_cnt - b0, 1);
    tick();
    check("same_ready_again", {awready, wready}, 2'b11);

    // SLVERR write to ID and SLVERR read held for 5 cycles
    awaddr = 32'h04; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h0C; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n = 0;
    while (!(bvalid && rvalid) && n < 20) begin tick(); n++; end
    check("hold_both_valid", {bvalid, rvalid}, 2'b11);
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (!(bvalid && rvalid && bresp == 2'b10 && rresp == 2'b10 && rdata == 32'h0)) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    check("hold_resp", {bresp, rresp, rdata}, {2'b10, 2'b10, 32'h0});
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check("hold_release", {bvalid, rvalid}, 2'b00);
    axi_read(32'h04, rd, resp);
    check("id_unchanged", rd, 32'h5D10_0402);

    // Reset during W_RESP and R_DATA
    awaddr = 32'h00; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h14; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n = 0;
    while (!(bvalid && rvalid) && n < 20) begin tick(); n++; end
    check("prerst_valid", {bvalid, rvalid}, 2'b11);
    aresetn = 1'b0;
    tick();
    check("midrst_valids", {bvalid, rvalid}, 2'b00);
    check("midrst_regs", {enable, value_update, awready, arready}, 7'd0);
    check("midrst_value", value, 0);
    aresetn = 1'b1;
    tick();
    check("midrst_ready_rise", {awready, wready, arready}, 3'b111);
    axi_write(32'h18, 32'h55, 4'hF, resp);
    check("post_rst_bresp", resp, 2'b00);
    axi_read(32'h18, rd, resp);
    check("post_rst_read", {resp, rd}, {2'b00, 32'h55});
    axi_read(32'h14, rd, resp);
    check("post_rst_shadow_cleared", rd, 32'h0);
    axi_read(32'h00, rd, resp);
    check("post_rst_enable_read", rd, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
